// File: rtl/wc_pkg.sv
// Shared wordcount datapath definitions: line/word geometry and lane slicing.
package wc_pkg;

  localparam int LINE_W     = 512;
  localparam int WORD_W     = 64;
  localparam int LANES      = LINE_W / WORD_W;
  localparam int LANE_IDX_W = $clog2(LANES);

  // Word idx of a packed line; word 0 occupies the LSBs.
  function automatic logic [WORD_W-1:0] lane_slice(
    input logic [LINE_W-1:0]     line,
    input logic [LANE_IDX_W-1:0] idx
  );
    return line[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/fifo_512_line_packer.sv
// Write-side packer: folds a narrow ready/valid word stream into wide lines
// and writes them into a FWFT line FIFO, honouring full/prog_full.
module fifo_512_line_packer
  import wc_pkg::*;
#(
  parameter int IN_W  = WORD_W,
  parameter int OUT_W = LINE_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [OUT_W-1:0] fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  input  logic             fifo_prog_full,
  output logic             busy,
  output logic [CNT_W-1:0] lines_written
);

  localparam int NUM_LANES = OUT_W / IN_W;
  localparam int LIDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0][IN_W-1:0] acc, acc_nxt;
  logic [LIDX_W-1:0]              lane_cnt;
  logic [OUT_W-1:0]               out_q;
  logic                           pend;
  logic [CNT_W-1:0]               lw_q;

  logic beat, last_lane, complete, wr;

  // A completed line can always be staged when the output register is free
  // or is being drained this very edge, so accepting never overflows it.
  assign s_ready    = !reset && !fifo_prog_full && (!pend || !fifo_full);
  assign beat       = s_valid && s_ready;
  assign last_lane  = (lane_cnt == LIDX_W'(NUM_LANES - 1));
  assign complete   = beat && (last_lane || s_last);
  assign wr         = pend && !fifo_full;

  assign fifo_wr_en    = wr;
  assign fifo_din      = out_q;
  assign lines_written = lw_q;
  assign busy          = pend || (lane_cnt != '0);

  // Per-lane merge: only the lane selected by lane_cnt takes the incoming word.
  // Lanes above it stay zero because acc is cleared whenever a line closes.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign acc_nxt[g] = (beat && lane_cnt == LIDX_W'(g)) ? s_data : acc[g];
  end

  // Accumulator and lane counter; both clear on the edge the line is handed off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      lane_cnt <= '0;
    end else if (complete) begin
      acc      <= '0;
      lane_cnt <= '0;
    end else if (beat) begin
      acc      <= acc_nxt;
      lane_cnt <= lane_cnt + 1'b1;
    end
  end

  // Output register: a new line may load on the same edge the old one is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      pend  <= 1'b0;
    end else if (complete) begin
      out_q <= acc_nxt;
      pend  <= 1'b1;
    end else if (wr) begin
      pend  <= 1'b0;
    end
  end

  // Count of FIFO writes since reset; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   lw_q <= '0;
    else if (wr) lw_q <= lw_q + 1'b1;
  end

endmodule

// File: tb/tb_fifo_512_line_packer.sv
// Self-checking bench for fifo_512_line_packer: scoreboard of expected lines.
module tb_fifo_512_line_packer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [511:0] fifo_din;
  logic         fifo_wr_en;
  logic         fifo_full = 1'b0;
  logic         fifo_prog_full = 1'b0;
  logic         busy;
  logic [31:0]  lines_written;

  fifo_512_line_packer dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full),
    .busy(busy), .lines_written(lines_written)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           stalls = 0;
  logic [511:0] sb[$];
  logic [511:0] cur = '0;
  int           cur_n = 0;
  logic [31:0]  exp_lw = '0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference packer: words fill lanes from the LSB; a line closes on last or lane 7.
  task automatic model_beat(input logic [63:0] d, input logic last);
    cur[cur_n*64 +: 64] = d;
    cur_n++;
    if (last || cur_n == 8) begin
      sb.push_back(cur);
      cur   = '0;
      cur_n = 0;
    end
  endtask

  // Present one word and hold it until the handshake completes (bounded).
  task automatic send(input logic [63:0] d, input logic last);
    bit ok = 0;
    int n = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      if (!ok) stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    else     model_beat(d, last);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Output monitor: every write is popped against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      chk("lines_written", lines_written, exp_lw);
      chk("no_wr_when_full", fifo_wr_en & fifo_full, 0);
      if (fifo_wr_en) begin
        if (sb.size() == 0) chk("unexpected_write", 1, 0);
        else                chk("line", fifo_din, sb.pop_front());
        exp_lw = exp_lw + 1;
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lines", lines_written, 0);
    chk("rst_din", fifo_din, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // two full lines at full rate
    stalls = 0;
    for (int i = 1; i <= 16; i++) send(64'(i), i == 16);
    repeat (3) @(negedge clk);
    chk("t1_stalls", stalls, 0);
    chk("t1_count", lines_written, 2);
    chk("t1_busy", busy, 0);
    @(posedge clk); #1;

    // short line closed by last, one-cycle write latency
    send(64'hA, 0);
    send(64'hB, 0);
    send(64'hC, 1);
    @(negedge clk);
    chk("t2_latency", fifo_wr_en, 1);
    chk("t2_line", fifo_din, {320'b0, 64'hC, 64'hB, 64'hA});
    @(posedge clk); #1;

    // FIFO full with a staged line: nothing written, nothing accepted
    for (int i = 0; i < 7; i++) send(64'h100 + 64'(i), 0);
    fifo_full = 1'b1;
    send(64'h107, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) send(64'h200 + 64'(i), 0);
      end
      begin
        repeat (20) begin
          @(negedge clk);
          chk("t3_ready_low", s_ready, 0);
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    chk("t3_count", lines_written, 5);
    @(posedge clk); #1;

    // prog_full mid-line
    for (int i = 0; i < 3; i++) send(64'h300 + 64'(i), 0);
    s_data = 64'h303; s_last = 1'b0; s_valid = 1'b1;
    fifo_prog_full = 1'b1;
    @(negedge clk);
    chk("t4_ready_drop", s_ready, 0);
    repeat (3) @(negedge clk);
    chk("t4_lane_hold", dut.lane_cnt, 3);
    chk("t4_busy", busy, 1);
    @(posedge clk); #1;
    fifo_prog_full = 1'b0;
    for (int i = 3; i < 8; i++) send(64'h300 + 64'(i), 0);
    repeat (3) @(negedge clk);
    chk("t4_drained", sb.size(), 0);
    @(posedge clk); #1;

    // reset mid-line discards the partial line
    for (int i = 0; i < 5; i++) send(64'h400 + 64'(i), 0);
    reset  = 1'b1;
    exp_lw = '0;
    cur    = '0;
    cur_n  = 0;
    @(negedge clk);
    chk("t5_wr_en", fifo_wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", s_ready, 0);
    chk("t5_lines", lines_written, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send(64'h500, 0);
    send(64'h501, 1);
    repeat (3) @(negedge clk);
    chk("t5_count", lines_written, 1);
    @(posedge clk); #1;

    // counter wrap
    #1;
    force dut.lw_q = 32'hFFFF_FFFF;
    exp_lw = 32'hFFFF_FFFF;
    #1;
    release dut.lw_q;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) send(64'h600 + 64'(i), i == 15);
    repeat (3) @(negedge clk);
    chk("t6_wrap", lines_written, 1);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
